// File: rtl/cs_arbiter_ctrl_if.sv
// Two-channel sample/result bundle for cs_arbiter_ctrl.
// Each xN channel uses valid/ready: a sample moves on a rising edge where xN_valid and xN_ready are both high;
// the source holds xN stable while xN_valid is high and not yet accepted. y_valid is a one-cycle result strobe with no back-pressure.
interface cs_arbiter_ctrl_if;
  logic [7:0] x0;
  logic       x0_valid;
  logic       x0_ready;
  logic [7:0] x1;
  logic       x1_valid;
  logic       x1_ready;
  logic [9:0] y;
  logic       y_valid;
  logic       y_ch;
  logic       busy;
  logic [2:0] state_dbg;

  modport master (
    output x0, x0_valid, x1, x1_valid,
    input  x0_ready, x1_ready, y, y_valid, y_ch, busy, state_dbg
  );

  modport slave (
    input  x0, x0_valid, x1, x1_valid,
    output x0_ready, x1_ready, y, y_valid, y_ch, busy, state_dbg
  );
endinterface

// File: rtl/cs_arbiter_ctrl.sv
// Two-channel arbiter in front of one serial engine: per-channel 9-sample window,
// y = (sum + 9*xappr) >> 3, where xappr is the largest window entry not above floor(sum/9).
module cs_arbiter_ctrl #(
    parameter bit FAIR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    cs_arbiter_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SUM  = 3'd1,
        S_DIV  = 3'd2,
        S_SCAN = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ch_q, ch_d;
    logic        last_served_q, last_served_d;
    logic [7:0]  win0_q [0:8];
    logic [7:0]  win0_d [0:8];
    logic [7:0]  win1_q [0:8];
    logic [7:0]  win1_d [0:8];
    logic [11:0] sum_q, sum_d;
    logic [11:0] quo_q, quo_d;
    logic [3:0]  rem_q, rem_d;
    logic [7:0]  avg_q, avg_d;
    logic [7:0]  xappr_q, xappr_d;
    logic [9:0]  y_q, y_d;
    logic        y_valid_q, y_valid_d;
    logic        y_ch_q, y_ch_d;

    logic        grant_ch;
    logic        idle_ok;
    logic        x0_rdy, x1_rdy;
    logic [3:0]  idx;
    logic [7:0]  cur;
    logic [4:0]  rem_sh;
    logic        q_bit;
    logic [11:0] quo_next;

    // Readies are forced low while reset is held so nothing is accepted during reset.
    always_comb begin
        grant_ch = 1'b0;
        if (bus.x0_valid && bus.x1_valid) begin
            grant_ch = FAIR ? ~last_served_q : 1'b0;
        end else begin
            grant_ch = bus.x1_valid;
        end
        idle_ok = (state_q == S_IDLE) && !reset;
        x0_rdy  = idle_ok && bus.x0_valid && !grant_ch;
        x1_rdy  = idle_ok && bus.x1_valid && grant_ch;
    end

    always_comb begin
        idx      = (cnt_q <= 4'd8) ? cnt_q : 4'd0;
        cur      = ch_q ? win1_q[idx] : win0_q[idx];
        rem_sh   = {rem_q, quo_q[11]};
        q_bit    = (rem_sh >= 5'd9);
        quo_next = {quo_q[10:0], q_bit};
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ch_d          = ch_q;
        last_served_d = last_served_q;
        win0_d        = win0_q;
        win1_d        = win1_q;
        sum_d         = sum_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        avg_d         = avg_q;
        xappr_d       = xappr_q;
        y_d           = y_q;
        y_valid_d     = 1'b0;
        y_ch_d        = y_ch_q;

        case (state_q)
            S_IDLE: begin
                if (x0_rdy || x1_rdy) begin
                    if (x1_rdy) begin
                        win1_d[0] = bus.x1;
                        for (int i = 1; i < 9; i++) win1_d[i] = win1_q[i-1];
                    end else begin
                        win0_d[0] = bus.x0;
                        for (int i = 1; i < 9; i++) win0_d[i] = win0_q[i-1];
                    end
                    ch_d          = x1_rdy;
                    last_served_d = x1_rdy;
                    sum_d         = 12'd0;
                    cnt_d         = 4'd0;
                    state_d       = S_SUM;
                end
            end
            S_SUM: begin
                sum_d = sum_q + {4'd0, cur};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd8) begin
                    cnt_d   = 4'd0;
                    quo_d   = sum_q + {4'd0, cur};
                    rem_d   = 4'd0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                // Restoring step: the remainder stays below 9, so four bits hold it between steps.
                rem_d = q_bit ? 4'(rem_sh - 5'd9) : rem_sh[3:0];
                quo_d = quo_next;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd11) begin
                    cnt_d   = 4'd0;
                    avg_d   = quo_next[7:0];
                    xappr_d = 8'd0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cur <= avg_q && cur >= xappr_q) xappr_d = cur;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd8) begin
                    cnt_d   = 4'd0;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                y_d       = 10'(({1'b0, sum_q} + {2'b00, xappr_q, 3'b000} + {5'd0, xappr_q}) >> 3);
                y_valid_d = 1'b1;
                y_ch_d    = ch_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            ch_q          <= 1'b0;
            last_served_q <= 1'b1;
            win0_q        <= '{default: 8'h00};
            win1_q        <= '{default: 8'h00};
            sum_q         <= 12'd0;
            quo_q         <= 12'd0;
            rem_q         <= 4'd0;
            avg_q         <= 8'd0;
            xappr_q       <= 8'd0;
            y_q           <= 10'd0;
            y_valid_q     <= 1'b0;
            y_ch_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ch_q          <= ch_d;
            last_served_q <= last_served_d;
            win0_q        <= win0_d;
            win1_q        <= win1_d;
            sum_q         <= sum_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
            avg_q         <= avg_d;
            xappr_q       <= xappr_d;
            y_q           <= y_d;
            y_valid_q     <= y_valid_d;
            y_ch_q        <= y_ch_d;
        end
    end

    assign bus.x0_ready  = x0_rdy;
    assign bus.x1_ready  = x1_rdy;
    assign bus.y         = y_q;
    assign bus.y_valid   = y_valid_q;
    assign bus.y_ch      = y_ch_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_cs_arbiter_ctrl.sv
// Directed bench for cs_arbiter_ctrl: one round-robin instance and one fixed-priority instance.
module tb_cs_arbiter_ctrl;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  cs_arbiter_ctrl_if bus_f ();
  cs_arbiter_ctrl_if bus_p ();

  cs_arbiter_ctrl #(.FAIR(1'b1)) u_dut_fair (.clk(clk), .reset(reset), .bus(bus_f));
  cs_arbiter_ctrl #(.FAIR(1'b0)) u_dut_fixed (.clk(clk), .reset(reset), .bus(bus_p));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // driver: one sample on the fair instance, returns the result and accept-to-y_valid edge count
  task automatic send(input bit ch, input logic [7:0] val,
                      output logic [9:0] y, output bit ych, output int lat);
    bit got;
    y = '0; ych = 1'b0; lat = 0; got = 1'b0;
    if (ch) begin bus_f.x1 = val; bus_f.x1_valid = 1'b1; end
    else    begin bus_f.x0 = val; bus_f.x0_valid = 1'b1; end
    #1;
    for (int n = 0; n < 50; n++) begin
      if ((ch ? bus_f.x1_ready : bus_f.x0_ready) === 1'b1) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_accept ch%0d: ready never seen, required 1", ch);
      bus_f.x0_valid = 1'b0; bus_f.x1_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus_f.x0_valid = 1'b0; bus_f.x1_valid = 1'b0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus_f.y_valid === 1'b1) break;
    end
    if (bus_f.y_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_result ch%0d: no y_valid within 40 edges, required one", ch);
    end
    y = bus_f.y; ych = bus_f.y_ch;
  endtask

  task automatic test_reset();
    bus_f.x0_valid = 1'b1; bus_f.x1_valid = 1'b1;
    bus_p.x0_valid = 1'b1; bus_p.x1_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus_f.y !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d required 0", bus_f.y); end
    checks++; if (bus_f.y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b required 0", bus_f.y_valid); end
    checks++; if (bus_f.y_ch !== 1'b0) begin errors++; $display("FAIL reset_y_ch: got %b required 0", bus_f.y_ch); end
    checks++; if (bus_f.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus_f.busy); end
    checks++;
    if ({bus_f.x0_ready, bus_f.x1_ready, bus_p.x0_ready, bus_p.x1_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b required 0000",
               {bus_f.x0_ready, bus_f.x1_ready, bus_p.x0_ready, bus_p.x1_ready});
    end
    bus_f.x0_valid = 1'b0; bus_f.x1_valid = 1'b0;
    bus_p.x0_valid = 1'b0; bus_p.x1_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [9:0] y; bit ych; int lat;
    apply_reset();
    send(1'b0, 8'd100, y, ych, lat);
    checks++; if (y !== 10'd12) begin errors++; $display("FAIL single_y: got %0d required 12", y); end
    checks++; if (ych !== 1'b0) begin errors++; $display("FAIL single_y_ch: got %b required 0", ych); end
    checks++; if (lat != 31) begin errors++; $display("FAIL single_latency: got %0d required 31", lat); end
    @(posedge clk); #1;
    checks++; if (bus_f.y_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: y_valid got %b required 0", bus_f.y_valid); end
    checks++; if (bus_f.y !== 10'd12) begin errors++; $display("FAIL single_hold: y got %0d required 12", bus_f.y); end
  endtask

  task automatic test_ramp();
    logic [9:0] y; bit ych; int lat;
    apply_reset();
    for (int i = 1; i <= 9; i++) send(1'b0, 8'(10 * i), y, ych, lat);
    checks++; if (y !== 10'd112) begin errors++; $display("FAIL ramp_y: got %0d required 112", y); end
    checks++; if (lat != 31) begin errors++; $display("FAIL ramp_latency: got %0d required 31", lat); end
  endtask

  task automatic test_saturate();
    logic [9:0] y; bit ych; int lat;
    apply_reset();
    for (int i = 0; i < 9; i++) send(1'b0, 8'd255, y, ych, lat);
    checks++; if (y !== 10'd573) begin errors++; $display("FAIL max_y: got %0d required 573", y); end
    for (int i = 0; i < 9; i++) send(1'b0, 8'd100, y, ych, lat);
    checks++; if (y !== 10'd225) begin errors++; $display("FAIL hundred_y: got %0d required 225", y); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_y [0:3];
    bit         exp_c [0:3];
    bit         grants [0:3];
    logic [9:0] ys [0:3];
    bit         ycs [0:3];
    int ng, nr, both, missed;
    bit want_grant;
    exp_y = '{10'd5, 10'd25, 10'd10, 10'd50};
    exp_c = '{1'b0, 1'b1, 1'b0, 1'b1};
    ng = 0; nr = 0; both = 0; missed = 0; want_grant = 1'b0;
    apply_reset();
    bus_f.x0 = 8'd40; bus_f.x1 = 8'd200;
    bus_f.x0_valid = 1'b1; bus_f.x1_valid = 1'b1;
    #1;
    for (int cyc = 0; cyc < 300 && nr < 4; cyc++) begin
      if (bus_f.x0_ready && bus_f.x1_ready) both++;
      if (want_grant && !(bus_f.x0_ready || bus_f.x1_ready)) missed++;
      want_grant = 1'b0;
      if ((bus_f.x0_ready || bus_f.x1_ready) && ng < 4) begin grants[ng] = bus_f.x1_ready; ng++; end
      @(posedge clk); #1;
      if (bus_f.y_valid) begin
        ys[nr] = bus_f.y; ycs[nr] = bus_f.y_ch; nr++;
        if (nr < 4) want_grant = 1'b1;
        else begin bus_f.x0_valid = 1'b0; bus_f.x1_valid = 1'b0; end
      end
      #1;
    end
    bus_f.x0_valid = 1'b0; bus_f.x1_valid = 1'b0;
    checks++; if (nr != 4) begin errors++; $display("FAIL rr_results: got %0d required 4", nr); end
    checks++; if (both != 0) begin errors++; $display("FAIL rr_onehot: both readys high %0d times, required 0", both); end
    checks++; if (missed != 0) begin errors++; $display("FAIL rr_next_edge: %0d late grants, required 0", missed); end
    for (int i = 0; i < 4; i++) begin
      if (i < nr) begin
        checks++; if (grants[i] !== exp_c[i]) begin errors++; $display("FAIL rr_grant%0d: got %b required %b", i, grants[i], exp_c[i]); end
        checks++; if (ycs[i] !== exp_c[i]) begin errors++; $display("FAIL rr_y_ch%0d: got %b required %b", i, ycs[i], exp_c[i]); end
        checks++; if (ys[i] !== exp_y[i]) begin errors++; $display("FAIL rr_y%0d: got %0d required %0d", i, ys[i], exp_y[i]); end
      end
    end
  endtask

  task automatic test_fixed_priority();
    logic [9:0] exp_y [0:3];
    bit         exp_c [0:3];
    logic [9:0] ys [0:3];
    bit         ycs [0:3];
    int nr, x1_early;
    bit drop_x1;
    exp_y = '{10'd5, 10'd10, 10'd15, 10'd25};
    exp_c = '{1'b0, 1'b0, 1'b0, 1'b1};
    nr = 0; x1_early = 0; drop_x1 = 1'b0;
    apply_reset();
    bus_p.x0 = 8'd40; bus_p.x1 = 8'd200;
    bus_p.x0_valid = 1'b1; bus_p.x1_valid = 1'b1;
    #1;
    for (int cyc = 0; cyc < 300 && nr < 4; cyc++) begin
      if (bus_p.x1_ready) begin
        if (bus_p.x0_valid) x1_early++;
        drop_x1 = 1'b1;
      end
      @(posedge clk); #1;
      if (drop_x1) begin bus_p.x1_valid = 1'b0; drop_x1 = 1'b0; end
      if (bus_p.y_valid) begin
        ys[nr] = bus_p.y; ycs[nr] = bus_p.y_ch; nr++;
        if (nr == 3) bus_p.x0_valid = 1'b0;
      end
      #1;
    end
    bus_p.x0_valid = 1'b0; bus_p.x1_valid = 1'b0;
    checks++; if (nr != 4) begin errors++; $display("FAIL fp_results: got %0d required 4", nr); end
    checks++; if (x1_early != 0) begin errors++; $display("FAIL fp_x1_ready: asserted %0d times while ch0 valid, required 0", x1_early); end
    for (int i = 0; i < 4; i++) begin
      if (i < nr) begin
        checks++; if (ycs[i] !== exp_c[i]) begin errors++; $display("FAIL fp_y_ch%0d: got %b required %b", i, ycs[i], exp_c[i]); end
        checks++; if (ys[i] !== exp_y[i]) begin errors++; $display("FAIL fp_y%0d: got %0d required %0d", i, ys[i], exp_y[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_div();
    logic [9:0] y; bit ych; int lat, stale;
    bit got;
    stale = 0; got = 1'b0;
    apply_reset();
    bus_f.x0 = 8'd77; bus_f.x0_valid = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      if (bus_f.x0_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!got) begin errors++; $display("FAIL mid_accept: ready got 0 required 1"); end
    @(posedge clk); #1;
    bus_f.x0_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checks++; if (bus_f.state_dbg !== 3'd2) begin errors++; $display("FAIL mid_in_div: state got %0d required 2", bus_f.state_dbg); end
    reset = 1'b1;
    #1;
    checks++; if (bus_f.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b required 0", bus_f.busy); end
    checks++; if (bus_f.y_valid !== 1'b0) begin errors++; $display("FAIL mid_y_valid: got %b required 0", bus_f.y_valid); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bus_f.y_valid !== 1'b0 || bus_f.busy !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale: %0d active cycles after reset, required 0", stale); end
    send(1'b1, 8'd100, y, ych, lat);
    checks++; if (y !== 10'd12) begin errors++; $display("FAIL mid_ch1_y: got %0d required 12", y); end
    checks++; if (ych !== 1'b1) begin errors++; $display("FAIL mid_ch1_y_ch: got %b required 1", ych); end
    checks++; if (lat != 31) begin errors++; $display("FAIL mid_ch1_latency: got %0d required 31", lat); end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1;
    bus_f.x0 = '0; bus_f.x0_valid = 1'b0; bus_f.x1 = '0; bus_f.x1_valid = 1'b0;
    bus_p.x0 = '0; bus_p.x0_valid = 1'b0; bus_p.x1 = '0; bus_p.x1_valid = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_ramp();
    test_saturate();
    test_back_to_back();
    test_fixed_priority();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cs_arbiter_ctrl.md
CS_ARBITER_CTRL -- requirements
Module: cs_arbiter_ctrl

Interface
REQ-001 SHALL have parameter FAIR, default 1: 1 = round-robin grant, 0 = fixed priority to channel 0.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port x0  in  8  channel-0 sample, unsigned.
REQ-005 SHALL have port x0_valid  in  1  channel-0 sample present; source holds x0 stable until accepted.
REQ-006 SHALL have port x0_ready  out  1  channel-0 sample accepted on this edge when x0_valid=1.
REQ-007 SHALL have ports x1, x1_valid, x1_ready  (8/1/1)  same meaning for channel 1.
REQ-008 SHALL have port y  out  10  computed result, unsigned.
REQ-009 SHALL have port y_valid  out  1  y valid, one-cycle pulse.
REQ-010 SHALL have port y_ch  out  1  channel that y belongs to.
REQ-011 SHALL have port busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL keep one 9-entry 8-bit sliding window per channel; an accepted sample shifts in as newest and the oldest is discarded; the other channel's window is untouched.
REQ-013 SHALL share one serial compute engine between the two channels, sequenced by the FSM IDLE -> SUM -> DIV -> SCAN -> OUT -> IDLE.
REQ-014 SHALL assert xN_ready only in IDLE and only for the granted channel; at most one ready high per cycle; no acceptance outside IDLE.
REQ-015 SHALL grant, in IDLE: only one valid -> that channel; both valid with FAIR=1 -> the channel not served last (last-served resets to 1, so channel 0 wins first); both valid with FAIR=0 -> channel 0.
REQ-016 SHALL on the accept edge shift the sample in, latch the granted channel, and enter SUM.
REQ-017 SHALL in SUM add one window entry per cycle into a 12-bit sum, 9 cycles.
REQ-018 SHALL in DIV compute avg = floor(sum/9), 8 bits, by 12-step restoring division, 12 cycles.
REQ-019 SHALL in SCAN take xappr = largest window entry <= avg, including equality, 9 cycles; xappr always exists.
REQ-020 SHALL in OUT register y = (sum + 9*xappr) >> 3 with a 13-bit intermediate truncated to 10 bits (max 573, no overflow), set y_ch, pulse y_valid, and return to IDLE.
REQ-021 SHALL raise y_valid 31 edges after the accept edge, for exactly one cycle; the earliest next accept is on the following edge.
REQ-022 SHALL hold y and y_ch between results; a valid not granted stays pending with no data loss.

Reset
REQ-023 SHALL on reset, asynchronously and at any FSM state, clear y=0, y_valid=0, y_ch=0, busy=0, both readys=0, all window entries=0, sum/avg/xappr=0 and last-served=1, and enter IDLE.
REQ-024 SHALL abort any in-flight computation on reset with no y_valid for it; the first edge after deassertion may accept.

Verification
REQ-025 Reset, ch0 sends one 100 -> y=12 (sum 100, avg 11, xappr 0), y_ch=0, y_valid 31 edges after accept.
REQ-026 Reset, ch0 sends 10,20,...,90 -> 9th result y=112 (sum 450, avg 50, xappr 50).
REQ-027 Ch0 sends nine 255 -> 9th result y=573; nine 100 -> y=225.
REQ-028 FAIR=1, both valid continuously -> grants and y_ch alternate 0,1,0,1; each window holds only its own samples.
REQ-029 FAIR=0, both valid continuously -> x1_ready never asserts; all results y_ch=0.
REQ-030 Reset pulsed mid-DIV -> y_valid, busy low at once, no stale result; then ch1 sends 100 -> y=12, y_ch=1.
